// File: rtl/pe_pkg.sv
// pe_pkg: shared types and arithmetic helpers for the systolic MAC processing element.
//
// Contents:
//   pe_state_e : accumulator state machine encoding (PE_IDLE, PE_ACCUM)
//   wide_t     : MAX_W+1 bit working width for the accumulator add
//   add_res_t  : sum plus overflow flag returned by sat_add
//   extend()   : sign/zero extension of a width-limited value into wide_t
//   sat_add()  : add with overflow detection and optional clamping
//
// The helpers take the operand width and signedness as arguments so one
// package serves every parameterisation of the PE. Callers pass elaboration
// constants, so the loops below unroll into plain wiring and compare logic.
package pe_pkg;

    // Largest supported accumulator width (ACC_W <= MAX_W).
    localparam int MAX_W = 64;

    typedef logic [MAX_W:0] wide_t;

    typedef enum logic {
        PE_IDLE  = 1'b0,
        PE_ACCUM = 1'b1
    } pe_state_e;

    typedef struct packed {
        logic  ovf;
        wide_t sum;
    } add_res_t;

    // Extend the low 'width' bits of 'value' to the full working width.
    function automatic wide_t extend(input logic [MAX_W-1:0] value,
                                     input int               width,
                                     input bit               is_signed);
        wide_t r;
        logic  fill;
        fill = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) begin
                fill = is_signed & value[i];
            end
        end
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < width) ? value[i] : fill;
        end
        r[MAX_W] = fill;
        return r;
    endfunction

    // Add two already-extended operands. Both fit in acc_w bits, so the true
    // sum always fits the MAX_W+1 bit working width and its top bit is the
    // true sign. Overflow means the sum leaves the acc_w-bit range; with
    // saturate set the low acc_w bits are replaced by the violated limit.
    function automatic add_res_t sat_add(input wide_t a,
                                         input wide_t b,
                                         input int    acc_w,
                                         input bit    is_signed,
                                         input bit    saturate);
        add_res_t res;
        wide_t    s;
        s       = a + b;
        res.ovf = 1'b0;
        for (int i = 0; i <= MAX_W; i++) begin
            if (is_signed) begin
                // Every bit from the acc_w sign position up must match the true sign.
                if (i >= acc_w - 1 && s[i] != s[MAX_W]) begin
                    res.ovf = 1'b1;
                end
            end else if (i >= acc_w && s[i]) begin
                res.ovf = 1'b1;
            end
        end
        res.sum = s;
        if (res.ovf && saturate) begin
            for (int i = 0; i <= MAX_W; i++) begin
                if (!is_signed) begin
                    res.sum[i] = (i < acc_w);
                end else if (i < acc_w - 1) begin
                    res.sum[i] = ~s[MAX_W];
                end else begin
                    res.sum[i] = s[MAX_W];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// pe_mul_stage: first pipeline stage of the systolic MAC PE.
//
// Registers the activation*weight product together with its valid/last
// qualifiers, and registers the operand forward path to the east/south
// neighbours. Everything here has a latency of one clock.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   valid, last         : operand pair qualifiers (last only counts with valid)
//   activation, weight  : BW-bit operands
//   prod                : registered 2*BW-bit product
//   prod_valid          : registered valid
//   prod_last           : registered valid & last
//   fwd_activation/...  : registered operand copies and framing for neighbours
module pe_mul_stage #(
    parameter int BW     = 8,
    parameter int SIGNED = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid,
    input  logic            last,
    input  logic [BW-1:0]   activation,
    input  logic [BW-1:0]   weight,
    output logic [2*BW-1:0] prod,
    output logic            prod_valid,
    output logic            prod_last,
    output logic [BW-1:0]   fwd_activation,
    output logic [BW-1:0]   fwd_weight,
    output logic            fwd_valid,
    output logic            fwd_last
);

    // Operands are extended to 2*BW before the multiply; the low 2*BW bits of
    // the product are then correct for both signed and unsigned operands.
    logic            act_fill;
    logic            wgt_fill;
    logic [2*BW-1:0] act_ext;
    logic [2*BW-1:0] wgt_ext;
    logic [2*BW-1:0] prod_c;

    assign act_fill = (SIGNED != 0) & activation[BW-1];
    assign wgt_fill = (SIGNED != 0) & weight[BW-1];
    assign act_ext  = {{BW{act_fill}}, activation};
    assign wgt_ext  = {{BW{wgt_fill}}, weight};
    assign prod_c   = act_ext * wgt_ext;

    always_ff @(posedge clock) begin
        if (reset) begin
            prod           <= '0;
            prod_valid     <= 1'b0;
            prod_last      <= 1'b0;
            fwd_activation <= '0;
            fwd_weight     <= '0;
            fwd_valid      <= 1'b0;
            fwd_last       <= 1'b0;
        end else begin
            prod           <= prod_c;
            prod_valid     <= valid;
            prod_last      <= valid & last;
            fwd_activation <= activation;
            fwd_weight     <= weight;
            fwd_valid      <= valid;
            fwd_last       <= valid & last;
        end
    end

endmodule

// File: rtl/pe_systolic_mac.sv
// pe_systolic_mac: multiply-accumulate processing element for a 2-D systolic array.
//
// Each valid operand pair is multiplied (stage 1, pe_mul_stage) and added into
// a running dot product (stage 2, this module). A term flagged last closes the
// dot product: the total is emitted as a one-cycle o_result_valid pulse and the
// accumulator restarts from zero for the next term. Operands and framing are
// forwarded to the neighbours one cycle later, independent of accumulation.
//
// Parameters: BW (operand width), ACC_W (accumulator width, >= 2*BW, <= 64),
//             SIGNED (two's-complement operands), SATURATE (clamp vs wrap).
//
// Ports:
//   i_clock, i_reset           : clock, synchronous active-high reset
//   i_valid, i_last            : operand pair valid, final term of dot product
//   i_activation, i_weight     : operands
//   o_activation, o_weight     : operands delayed by one cycle
//   o_valid, o_last            : i_valid and i_valid&i_last delayed by one cycle
//   o_result, o_result_valid   : completed dot product and its one-cycle strobe
//   o_overflow                 : some add in that dot product clamped/wrapped
//
// Handshake: there is no backpressure. A pair is consumed in every cycle that
// i_valid is high; i_last is ignored unless i_valid is also high.
module pe_systolic_mac
    import pe_pkg::*;
#(
    parameter int BW       = 8,
    parameter int ACC_W    = 32,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [BW-1:0]    i_activation,
    input  logic [BW-1:0]    i_weight,
    output logic [BW-1:0]    o_activation,
    output logic [BW-1:0]    o_weight,
    output logic             o_valid,
    output logic             o_last,
    output logic [ACC_W-1:0] o_result,
    output logic             o_result_valid,
    output logic             o_overflow
);

    logic [2*BW-1:0] prod;
    logic            v1;
    logic            l1;

    pe_mul_stage #(
        .BW     (BW),
        .SIGNED (SIGNED)
    ) u_mul (
        .clock          (i_clock),
        .reset          (i_reset),
        .valid          (i_valid),
        .last           (i_last),
        .activation     (i_activation),
        .weight         (i_weight),
        .prod           (prod),
        .prod_valid     (v1),
        .prod_last      (l1),
        .fwd_activation (o_activation),
        .fwd_weight     (o_weight),
        .fwd_valid      (o_valid),
        .fwd_last       (o_last)
    );

    pe_state_e        state;
    pe_state_e        state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             sticky;
    logic             sticky_next;
    logic [ACC_W-1:0] result_next;
    logic             result_valid_next;
    logic             overflow_next;

    logic [MAX_W-1:0] prod_pad;
    logic [MAX_W-1:0] acc_pad;
    wide_t            prod_ext;
    wide_t            base;
    add_res_t         add_out;
    logic             unused_sum_bits;

    always_comb begin
        prod_pad              = '0;
        prod_pad[2*BW-1:0]    = prod;
        acc_pad               = '0;
        acc_pad[ACC_W-1:0]    = acc;
    end

    // In IDLE there is no partial sum, so the first term is added to zero.
    assign prod_ext = extend(prod_pad, 2 * BW, SIGNED != 0);
    assign base     = (state == PE_ACCUM) ? extend(acc_pad, ACC_W, SIGNED != 0) : '0;
    assign add_out  = sat_add(base, prod_ext, ACC_W, SIGNED != 0, SATURATE != 0);

    // Only the low ACC_W bits of the working sum are stored.
    assign unused_sum_bits = ^add_out.sum[MAX_W:ACC_W];

    always_comb begin
        state_next        = state;
        acc_next          = acc;
        sticky_next       = sticky;
        result_next       = o_result;
        result_valid_next = 1'b0;
        overflow_next     = o_overflow;
        if (v1) begin
            if (l1) begin
                // Closing term: emit the total and restart from an empty sum.
                result_next       = add_out.sum[ACC_W-1:0];
                result_valid_next = 1'b1;
                overflow_next     = sticky | add_out.ovf;
                acc_next          = '0;
                sticky_next       = 1'b0;
                state_next        = PE_IDLE;
            end else begin
                acc_next    = add_out.sum[ACC_W-1:0];
                sticky_next = sticky | add_out.ovf;
                state_next  = PE_ACCUM;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= PE_IDLE;
            acc            <= '0;
            sticky         <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            state          <= state_next;
            acc            <= acc_next;
            sticky         <= sticky_next;
            o_result       <= result_next;
            o_result_valid <= result_valid_next;
            o_overflow     <= overflow_next;
        end
    end

endmodule

// File: tb/tb_pe_systolic_mac.sv
// tb_pe_systolic_mac: directed, table-driven bench for pe_systolic_mac.
//
// Four instances share the stimulus: 0 unsigned 8/32 saturating, 1 signed
// 8/32 saturating, 2 unsigned 8/16 saturating, 3 unsigned 8/16 wrapping.
// Each table row is applied at a falling edge and the selected instance is
// checked at the next falling edge (one rising edge later). Rows with rst
// set pulse the shared reset; every segment starts with one.
module tb_pe_systolic_mac;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       last;
    logic [7:0] act;
    logic [7:0] wgt;

    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic [7:0]  fa0, fa1, fa2, fa3;
    logic [7:0]  fw0, fw1, fw2, fw3;
    logic        fv0, fv1, fv2, fv3;
    logic        fl0, fl1, fl2, fl3;
    logic [31:0] res0, res1;
    logic [15:0] res2, res3;
    logic        rv0, rv1, rv2, rv3;
    logic        ov0, ov1, ov2, ov3;

    pe_systolic_mac #(.BW(8), .ACC_W(32), .SIGNED(0), .SATURATE(1)) dut_u (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_last(last),
        .i_activation(act), .i_weight(wgt),
        .o_activation(fa0), .o_weight(fw0), .o_valid(fv0), .o_last(fl0),
        .o_result(res0), .o_result_valid(rv0), .o_overflow(ov0));

    pe_systolic_mac #(.BW(8), .ACC_W(32), .SIGNED(1), .SATURATE(1)) dut_s (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_last(last),
        .i_activation(act), .i_weight(wgt),
        .o_activation(fa1), .o_weight(fw1), .o_valid(fv1), .o_last(fl1),
        .o_result(res1), .o_result_valid(rv1), .o_overflow(ov1));

    pe_systolic_mac #(.BW(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_last(last),
        .i_activation(act), .i_weight(wgt),
        .o_activation(fa2), .o_weight(fw2), .o_valid(fv2), .o_last(fl2),
        .o_result(res2), .o_result_valid(rv2), .o_overflow(ov2));

    pe_systolic_mac #(.BW(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) dut_wrap (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_last(last),
        .i_activation(act), .i_weight(wgt),
        .o_activation(fa3), .o_weight(fw3), .o_valid(fv3), .o_last(fl3),
        .o_result(res3), .o_result_valid(rv3), .o_overflow(ov3));

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  sel;
        logic        rst;
        logic        v;
        logic        l;
        logic [7:0]  a;
        logic [7:0]  w;
        logic        erv;
        logic [31:0] eres;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] sel, input logic r, input logic v,
                                input logic l, input logic [7:0] a, input logic [7:0] w,
                                input logic erv, input logic [31:0] eres, input logic eovf);
        vec_t t;
        t.sel = sel; t.rst = r; t.v = v; t.l = l; t.a = a; t.w = w;
        t.erv = erv; t.eres = eres; t.eovf = eovf;
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] res_model[4];

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, want);
        end
    endtask

    // ---------------- driver / monitor ----------------
    task automatic drive_row(input vec_t t);
        rst   = t.rst;
        valid = t.v;
        last  = t.l;
        act   = t.a;
        wgt   = t.w;
    endtask

    task automatic sample(input logic [1:0] sel, output logic [7:0] a, output logic [7:0] w,
                          output logic v, output logic l, output logic [31:0] r,
                          output logic rv, output logic ov);
        case (sel)
            2'd0:    begin a = fa0; w = fw0; v = fv0; l = fl0; r = res0;          rv = rv0; ov = ov0; end
            2'd1:    begin a = fa1; w = fw1; v = fv1; l = fl1; r = res1;          rv = rv1; ov = ov1; end
            2'd2:    begin a = fa2; w = fw2; v = fv2; l = fl2; r = {16'h0, res2}; rv = rv2; ov = ov2; end
            default: begin a = fa3; w = fw3; v = fv3; l = fl3; r = {16'h0, res3}; rv = rv3; ov = ov3; end
        endcase
    endtask

    initial begin
        logic [7:0]  s_a, s_w;
        logic        s_v, s_l, s_rv, s_ov;
        logic [31:0] s_r;
        vec_t        t;

        // Segment 0: unsigned 8/32 saturating
        tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,   0, 0));   // reset state
        tbl.push_back(mk(0, 0, 1, 0,   1,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 0,   1,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 0,   1,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 1,   1,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 1,   4, 0));   // 1+1+1+1
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));   // result holds 4
        tbl.push_back(mk(0, 0, 1, 0, 128,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));   // bubble
        tbl.push_back(mk(0, 0, 1, 0, 128,   2, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));   // bubble
        tbl.push_back(mk(0, 0, 1, 1, 128,   3, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 1, 768, 0));   // 128*(1+2+3)
        tbl.push_back(mk(0, 0, 0, 1,   5,   5, 0,   0, 0));   // last without valid
        tbl.push_back(mk(0, 0, 1, 0,   2,   3, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 1,   1,   4, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 1,  10, 0));   // 6+4
        tbl.push_back(mk(0, 0, 1, 1,   3,   3, 0,   0, 0));   // back-to-back singles
        tbl.push_back(mk(0, 0, 1, 1,   2,   2, 1,   9, 0));
        tbl.push_back(mk(0, 0, 1, 0,   7,   1, 1,   4, 0));   // fresh sum right after last
        tbl.push_back(mk(0, 0, 1, 1,   1,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 1,   8, 0));   // 7+1, no leakage
        tbl.push_back(mk(0, 0, 1, 0,  10,  10, 0,   0, 0));   // aborted sum
        tbl.push_back(mk(0, 0, 1, 0,  10,  10, 0,   0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,   0, 0));   // reset mid-sum
        tbl.push_back(mk(0, 0, 1, 1,   1,   1, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 1,   1, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 0,   2,   2, 0,   0, 0));
        tbl.push_back(mk(0, 1, 1, 1,   3,   3, 0,   0, 0));   // reset with last at input
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 1,   3,   3, 0,   0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,   0, 0));   // reset with last in accumulate stage
        tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,   0, 0));
        // Segment 1: signed 8/32
        tbl.push_back(mk(1, 1, 0, 0,   0,   0, 0,   0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'hFD, 5, 0,   0, 0));   // -3*5
        tbl.push_back(mk(1, 0, 1, 1,   2,   4, 0,   0, 0));
        tbl.push_back(mk(1, 0, 1, 1,   1,   1, 1, 32'hFFFFFFF9, 0)); // -15+8
        tbl.push_back(mk(1, 0, 1, 1, 8'h80, 8'h80, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8'h80, 8'h7F, 1, 32'd16384, 0)); // -128*-128
        tbl.push_back(mk(1, 0, 0, 0,   0,   0, 1, 32'hFFFFC080, 0)); // -128*127
        tbl.push_back(mk(1, 0, 0, 0,   0,   0, 0,   0, 0));
        // Segment 2: unsigned 8/16 saturating
        tbl.push_back(mk(2, 1, 0, 0,   0,   0, 0,   0, 0));
        tbl.push_back(mk(2, 0, 1, 0, 255, 255, 0,   0, 0));
        tbl.push_back(mk(2, 0, 1, 1, 255, 255, 0,   0, 0));
        tbl.push_back(mk(2, 0, 0, 0,   0,   0, 1, 65535, 1));
        tbl.push_back(mk(2, 0, 1, 0, 255, 255, 0,   0, 0));
        tbl.push_back(mk(2, 0, 1, 0, 255, 255, 0,   0, 0));
        tbl.push_back(mk(2, 0, 1, 1,   0,   0, 0,   0, 0));
        tbl.push_back(mk(2, 0, 1, 1,   1,   1, 1, 65535, 1)); // clamped value kept, flag sticky
        tbl.push_back(mk(2, 0, 0, 0,   0,   0, 1,   1, 0));   // flag cleared for next product
        // Segment 3: unsigned 8/16 wrapping
        tbl.push_back(mk(3, 1, 0, 0,   0,   0, 0,   0, 0));
        tbl.push_back(mk(3, 0, 1, 0, 255, 255, 0,   0, 0));
        tbl.push_back(mk(3, 0, 1, 1, 255, 255, 0,   0, 0));
        tbl.push_back(mk(3, 0, 0, 0,   0,   0, 1, 64514, 1));
        tbl.push_back(mk(3, 0, 1, 0, 255, 255, 0,   0, 0));
        tbl.push_back(mk(3, 0, 1, 0, 255, 255, 0,   0, 0));
        tbl.push_back(mk(3, 0, 1, 1,   0,   0, 0,   0, 0));
        tbl.push_back(mk(3, 0, 1, 1,   1,   1, 1, 64514, 1));
        tbl.push_back(mk(3, 0, 0, 0,   0,   0, 1,   1, 0));

        rst = 1'b1; valid = 1'b0; last = 1'b0; act = '0; wgt = '0;
        for (int k = 0; k < 4; k++) res_model[k] = '0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            if (t.erv) exp_q.push_back(t.eres);
            drive_row(t);
            @(posedge clk);
            @(negedge clk);
            sample(t.sel, s_a, s_w, s_v, s_l, s_r, s_rv, s_ov);

            if (t.rst) begin
                for (int k = 0; k < 4; k++) res_model[k] = '0;
            end else if (t.erv) begin
                res_model[t.sel] = t.eres;
            end

            check("fwd_activation", i, {24'h0, s_a}, t.rst ? 32'h0 : {24'h0, t.a});
            check("fwd_weight",     i, {24'h0, s_w}, t.rst ? 32'h0 : {24'h0, t.w});
            check("fwd_valid",      i, {31'h0, s_v}, {31'h0, ~t.rst & t.v});
            check("fwd_last",       i, {31'h0, s_l}, {31'h0, ~t.rst & t.v & t.l});
            check("result_valid",   i, {31'h0, s_rv}, {31'h0, t.erv});
            check("result",         i, s_r, res_model[t.sel]);
            if (t.erv || t.rst) check("overflow", i, {31'h0, s_ov}, {31'h0, t.eovf});

            if (s_rv) begin
                if (exp_q.size() == 0) check("unexpected_pulse", i, 32'h1, 32'h0);
                else                   check("sb_result", i, s_r, exp_q.pop_front());
            end
        end

        check("sb_leftover", tbl.size(), exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
